hand_packet_receiver: RTL
=========================

# hand_packet_receiver

Camera-1-side UART receiver for the inter-board hand-tracking link. Deserializes the 8N1 byte stream that camera 2 transmits on its data line (jc[1]), locks onto the 3×0xFF sync preamble, and reassembles the 6-byte payload into four 12-bit hand coordinates. Coordinates are presented atomically with a one-cycle strobe to the fusion/game logic in the 65 MHz domain.

## Interface
- CLKS_PER_BIT, default 564: clocks per UART bit (65 MHz / 115200).
- TIMEOUT_CLKS, default 65000: maximum idle gap between payload bytes before abort.
- clk_65mhz  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  reset; synchronous, active-high.
- rx_in  input  1  asynchronous serial line; idle high.
- hand_x_left_top  output  12  last good packet, top x.
- hand_y_left_top  output  12  last good packet, top y.
- hand_x_left_bottom  output  12  last good packet, bottom x.
- hand_y_left_bottom  output  12  last good packet, bottom y.
- new_data_out  output  1  one-cycle strobe: coordinate outputs just updated.
- frame_err_out  output  1  one-cycle strobe: stop-bit error or payload timeout.
- synced_out  output  1  high while the payload is being collected.

## Operation
- rx_in passes through a 2-FF synchronizer; all further logic uses the synchronized bit.
- Byte FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE: on synchronized line 1→0 transition, clear baud counter and go to RX_START. A line held low never retriggers.
  - RX_START: after CLKS_PER_BIT/2 clocks sample; if 1 (glitch), return to RX_IDLE silently, else go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT clocks, 8 bits LSB first.
  - RX_STOP: sample after CLKS_PER_BIT; 1 → byte_valid for one cycle with the byte; 0 → byte_err for one cycle. Either way return to RX_IDLE.
- Packet FSM (HUNT, PAYLOAD):
  - HUNT: ff_cnt (2 bits, saturating at 3) increments on each valid 0xFF byte. A valid non-FF byte with ff_cnt==3 is stored as payload byte 0 and moves to PAYLOAD with idx=1; with ff_cnt<3 it clears ff_cnt.
  - PAYLOAD: bytes 1..5 stored in order regardless of value (0xFF included). After byte 5: update all outputs, pulse new_data_out, return to HUNT, ff_cnt=0.
  - Payload order: b0=x_top[11:4], b1=y_top[7:0], b2={x_top[3:0],y_top[11:8]}, b3=x_bot[11:4], b4=y_bot[7:0], b5={x_bot[3:0],y_bot[11:8]}.
  - byte_err in any state: pulse frame_err_out, ff_cnt=0, go to HUNT, discard partial payload.
  - In PAYLOAD, gap counter clears on every byte_valid; when it reaches TIMEOUT_CLKS: pulse frame_err_out, go to HUNT.
- Outputs change only on a completed packet; a partial or aborted packet never alters them.
- synced_out = (state == PAYLOAD).

## Timing
- Reset: all coordinate outputs 0, new_data_out 0, frame_err_out 0, synced_out 0; both FSMs idle/HUNT, counters 0. Reset mid-byte or mid-packet discards everything.
- Synchronizer latency 2 cycles; byte_valid fires 1 cycle after stop-bit mid-sample.
- Coordinate outputs and new_data_out become valid the cycle after byte 5's byte_valid; all four coordinates change in the same cycle.
- Preamble of 4+ FFs is legal (ff_cnt saturates); packets back to back with no gap are legal.
- No backpressure; consumer must sample on new_data_out.

## Test plan
- Reset: sys_rst high 5 cycles with rx_in toggling -> all outputs 0, no strobes.
- Clean packet (CLKS_PER_BIT=16): FF FF FF 12 AB 32 0F C4 01 -> x_top=0x123, y_top=0x2AB, x_bot=0x0F0, y_bot=0x1C4, one new_data_out pulse.
- Short preamble: FF FF 12 AB 32 0F C4 01 -> no strobe, outputs unchanged; following full packet decodes correctly.
- Stop-bit error on byte b3 -> frame_err_out pulse, outputs keep previous packet, next valid packet decodes.
- 0xFF inside payload (b4=FF) and 5-FF preamble -> y_bot[7:0]=0xFF decoded, one strobe.
- Glitch: 4-clock low pulse on idle line -> no byte; stall >TIMEOUT_CLKS after b2 -> frame_err_out pulse, return to HUNT.

Source files
------------

// File: rtl/hand_packet_receiver.sv
// rtl/hand_packet_receiver.sv - 8N1 UART receiver and sync-framed hand coordinate packet decoder
//
// Purpose: deserializes the camera-2 hand-tracking byte stream, locks onto a
// 3x0xFF preamble and unpacks a 6-byte payload into four 12-bit coordinates.
//
// Ports:
//   clk_65mhz          system clock, rising edge
//   sys_rst            synchronous active-high reset
//   rx_in              asynchronous serial line, idle high
//   hand_x_left_top    last good packet, top x
//   hand_y_left_top    last good packet, top y
//   hand_x_left_bottom last good packet, bottom x
//   hand_y_left_bottom last good packet, bottom y
//   new_data_out       one-cycle strobe, coordinates just updated
//   frame_err_out      one-cycle strobe, stop-bit error or payload timeout
//   synced_out         high while the payload is being collected
module hand_packet_receiver #(
  parameter int CLKS_PER_BIT = 564,
  parameter int TIMEOUT_CLKS = 65000
) (
  input  logic        clk_65mhz,
  input  logic        sys_rst,
  input  logic        rx_in,
  output logic [11:0] hand_x_left_top,
  output logic [11:0] hand_y_left_top,
  output logic [11:0] hand_x_left_bottom,
  output logic [11:0] hand_y_left_bottom,
  output logic        new_data_out,
  output logic        frame_err_out,
  output logic        synced_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {HUNT, PAYLOAD} pkt_state_t;

  // Synchronizer; rx_prev is one more stage used only for falling-edge detect.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk_65mhz) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t        rx_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_err;

  always_ff @(posedge clk_65mhz) begin
    if (sys_rst) begin
      rx_state   <= RX_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          // Edge, not level: a line stuck low after a bad stop bit never retriggers.
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  pkt_state_t       pkt_state;
  logic [1:0]       ff_cnt;
  logic [2:0]       idx;
  logic [7:0]       pl [5];
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk_65mhz) begin
    if (sys_rst) begin
      pkt_state          <= HUNT;
      ff_cnt             <= '0;
      idx                <= '0;
      gap_cnt            <= '0;
      for (int i = 0; i < 5; i++) pl[i] <= '0;
      hand_x_left_top    <= '0;
      hand_y_left_top    <= '0;
      hand_x_left_bottom <= '0;
      hand_y_left_bottom <= '0;
      new_data_out       <= 1'b0;
      frame_err_out      <= 1'b0;
    end else begin
      new_data_out  <= 1'b0;
      frame_err_out <= 1'b0;
      if (byte_err) begin
        frame_err_out <= 1'b1;
        ff_cnt        <= '0;
        gap_cnt       <= '0;
        pkt_state     <= HUNT;
      end else begin
        case (pkt_state)
          HUNT: begin
            gap_cnt <= '0;
            if (byte_valid) begin
              if (byte_data == 8'hFF) begin
                if (ff_cnt != 2'd3) ff_cnt <= ff_cnt + 2'd1;
              end else if (ff_cnt == 2'd3) begin
                // Preamble is consumed here so an aborted payload must re-sync.
                pl[0]     <= byte_data;
                idx       <= 3'd1;
                ff_cnt    <= '0;
                pkt_state <= PAYLOAD;
              end else begin
                ff_cnt <= '0;
              end
            end
          end
          PAYLOAD: begin
            if (byte_valid) begin
              gap_cnt <= '0;
              if (idx == 3'd5) begin
                // Last byte is used straight from the receiver, not stored.
                hand_x_left_top    <= {pl[0], pl[2][7:4]};
                hand_y_left_top    <= {pl[2][3:0], pl[1]};
                hand_x_left_bottom <= {pl[3], byte_data[7:4]};
                hand_y_left_bottom <= {byte_data[3:0], pl[4]};
                new_data_out       <= 1'b1;
                ff_cnt             <= '0;
                pkt_state          <= HUNT;
              end else begin
                pl[idx] <= byte_data;
                idx     <= idx + 3'd1;
              end
            end else if (gap_cnt == GAP_MAX) begin
              frame_err_out <= 1'b1;
              ff_cnt        <= '0;
              gap_cnt       <= '0;
              pkt_state     <= HUNT;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: pkt_state <= HUNT;
        endcase
      end
    end
  end

  assign synced_out = (pkt_state == PAYLOAD);

endmodule
